// File: rtl/simon_pkg.sv
// ============================================================================
// Module      : simon_pkg
// Description : Shared Simon32/64 constants, state encoding and rotate helpers
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package simon_pkg;

  localparam int          SIMON_WORD   = 16;
  localparam int          SIMON_ROUNDS = 32;
  localparam logic [15:0] SIMON_C      = 16'hFFFC;
  // Leftmost bit is index 0 of the z0 sequence.
  localparam logic [61:0] SIMON_Z0     =
    62'b11111010001001010110000111001101111101000100101011000011100110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } simon_state_e;

  function automatic logic [15:0] rol1(input logic [15:0] v);
    return {v[14:0], v[15]};
  endfunction

  function automatic logic [15:0] rol2(input logic [15:0] v);
    return {v[13:0], v[15:14]};
  endfunction

  function automatic logic [15:0] rol8(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  function automatic logic [15:0] ror1(input logic [15:0] v);
    return {v[0], v[15:1]};
  endfunction

  function automatic logic [15:0] ror3(input logic [15:0] v);
    return {v[2:0], v[15:3]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/simon_encrypt_if.sv
// ============================================================================
// Module      : simon_encrypt_if
// Description : Nibble-serial load/unload and status bundle of the encrypt engine
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface simon_encrypt_if;
  logic       shift;
  logic       start;
  logic [3:0] data_in;
  logic [3:0] data_out;
  logic       busy;
  logic       done;

  modport master (output shift, start, data_in, input data_out, busy, done);
  modport slave  (input shift, start, data_in, output data_out, busy, done);
endinterface

`default_nettype wire

// File: rtl/simon_enc_round.sv
// ============================================================================
// Module      : simon_enc_round
// Description : One combinational Simon32/64 round plus next key word
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module simon_enc_round
  import simon_pkg::*;
(
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] k0,
  input  logic [15:0] k1,
  input  logic [15:0] k3,
  input  logic        z,
  output logic [15:0] x_next,
  output logic [15:0] y_next,
  output logic [15:0] knew
);

  logic [15:0] w_f;
  logic [15:0] w_tmp;

  assign w_f    = (rol1(x) & rol8(x)) ^ rol2(x);
  assign x_next = y ^ w_f ^ k0;
  assign y_next = x;

  // SIMON_C folds the key inversion and the constant 3 into one XOR.
  assign w_tmp  = ror3(k3) ^ k1;
  assign knew   = SIMON_C ^ {15'd0, z} ^ k0 ^ w_tmp ^ ror1(w_tmp);

endmodule

`default_nettype wire

// File: rtl/simon_encrypt.sv
// ============================================================================
// Module      : simon_encrypt
// Description : Simon32/64 encrypt engine, nibble-serial I/O, one round per clock
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module simon_encrypt
  import simon_pkg::*;
#(
  parameter int ROUNDS = SIMON_ROUNDS
) (
  input  logic            clk,
  input  logic            rst_n,
  simon_encrypt_if.slave  bus
);

  localparam int            CW     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [CW-1:0] c_last = CW'(ROUNDS - 1);

  simon_state_e  r_state;
  simon_state_e  w_state_next;
  logic [95:0]   r_chain;
  logic [95:0]   w_chain_next;
  logic [CW-1:0] r_round;
  logic [CW-1:0] w_round_next;

  logic [15:0]   w_x_next;
  logic [15:0]   w_y_next;
  logic [15:0]   w_knew;
  logic [5:0]    w_zidx;
  logic          w_z;

  assign w_zidx = 6'd61 - 6'(r_round);
  assign w_z    = SIMON_Z0[w_zidx];

  // Chain layout: {x, y, k3, k2, k1, k0}
  simon_enc_round u_round (
    .x      (r_chain[95:80]),
    .y      (r_chain[79:64]),
    .k0     (r_chain[15:0]),
    .k1     (r_chain[31:16]),
    .k3     (r_chain[63:48]),
    .z      (w_z),
    .x_next (w_x_next),
    .y_next (w_y_next),
    .knew   (w_knew)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_chain <= '0;
      r_round <= '0;
    end else begin
      r_state <= w_state_next;
      r_chain <= w_chain_next;
      r_round <= w_round_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_chain_next = r_chain;
    w_round_next = r_round;
    case (r_state)
      IDLE: begin
        if (bus.shift) begin
          w_chain_next = {r_chain[91:0], bus.data_in};
        end else if (bus.start) begin
          w_state_next = RUN;
          w_round_next = '0;
        end
      end
      RUN: begin
        w_chain_next = {w_x_next, w_y_next, w_knew, r_chain[63:16]};
        if (r_round == c_last) begin
          w_state_next = DONE;
        end else begin
          w_round_next = r_round + CW'(1);
        end
      end
      DONE: begin
        if (bus.shift) begin
          w_chain_next = {r_chain[91:0], bus.data_in};
          w_state_next = IDLE;
        end else if (bus.start) begin
          w_state_next = RUN;
          w_round_next = '0;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign bus.data_out = r_chain[95:92];
  assign bus.busy     = (r_state == RUN);
  assign bus.done     = (r_state == DONE);

endmodule

`default_nettype wire
